// File: rtl/cache_access_sequencer.sv
// Per-request controller for a 4-way set-associative cache: tag lookup, victim
// writeback, line refill, tag install, LRU update pulses and hit/miss statistics.
module cache_access_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 4,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    // CPU request / response
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               req_we,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hit,
    output logic [3:0]         resp_way,
    // tag array / LRU lookup
    output logic [INDEX_W-1:0] lookup_index,
    input  logic [3:0]         lookup_hit_way,
    input  logic [3:0]         victim_way,
    input  logic               victim_valid,
    input  logic               victim_dirty,
    input  logic [TAG_W-1:0]   victim_tag,
    // metadata write
    output logic               meta_we,
    output logic [3:0]         meta_way,
    output logic [TAG_W-1:0]   meta_tag,
    output logic               meta_dirty,
    // LRU update
    output logic               lru_update,
    output logic [3:0]         lru_access_way,
    // memory bus
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    // statistics / status
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count,
    output logic               err_multi_hit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_INSTALL,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               we_q, we_d;
    logic [3:0]         vic_way_q, vic_way_d;
    logic [TAG_W-1:0]   vic_tag_q, vic_tag_d;
    logic               resp_hit_q, resp_hit_d;
    logic [3:0]         resp_way_q, resp_way_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               err_q, err_d;

    // Lowest set bit wins when the tag match or LRU vector is not one-hot.
    logic [3:0] hit_lo, vic_lo, vic_sel;
    logic       any_hit, multi_hit;

    assign hit_lo    = lookup_hit_way & (~lookup_hit_way + 4'd1);
    assign vic_lo    = victim_way & (~victim_way + 4'd1);
    assign vic_sel   = (victim_way == 4'd0) ? 4'b0001 : vic_lo;
    assign any_hit   = (lookup_hit_way != 4'd0);
    assign multi_hit = ((lookup_hit_way & (lookup_hit_way - 4'd1)) != 4'd0);

    // Line offset is irrelevant to a line-granular controller.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    always_comb begin
        // NOTE: every output and next-state value gets a default before the case,
        // so no path through the block leaves a variable unassigned (no latches).
        state_d        = state_q;
        tag_d          = tag_q;
        index_d        = index_q;
        we_d           = we_q;
        vic_way_d      = vic_way_q;
        vic_tag_d      = vic_tag_q;
        resp_hit_d     = resp_hit_q;
        resp_way_d     = resp_way_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        err_d          = err_q;

        meta_we        = 1'b0;
        meta_way       = vic_way_q;
        meta_tag       = tag_q;
        meta_dirty     = we_q;
        lru_update     = 1'b0;
        lru_access_way = vic_way_q;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = {tag_q, index_q, {OFFSET_W{1'b0}}};

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d   = req_addr[ADDR_W-1 -: TAG_W];
                    index_d = req_addr[OFFSET_W +: INDEX_W];
                    we_d    = req_we;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (any_hit) begin
                    lru_update     = 1'b1;
                    lru_access_way = hit_lo;
                    meta_we        = we_q;
                    meta_way       = hit_lo;
                    meta_dirty     = 1'b1;
                    resp_hit_d     = 1'b1;
                    resp_way_d     = hit_lo;
                    err_d          = err_q | multi_hit;
                    hit_cnt_d      = (hit_cnt_q == {CNT_W{1'b1}}) ? hit_cnt_q : hit_cnt_q + 1'b1;
                    state_d        = S_RESP;
                end else begin
                    vic_way_d  = vic_sel;
                    vic_tag_d  = victim_tag;
                    resp_hit_d = 1'b0;
                    resp_way_d = vic_sel;
                    miss_cnt_d = (miss_cnt_q == {CNT_W{1'b1}}) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    state_d    = (victim_valid && victim_dirty) ? S_WB_REQ : S_FILL_REQ;
                end
            end

            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vic_tag_q, index_q, {OFFSET_W{1'b0}}};
                if (mem_req_ready) state_d = S_WB_WAIT;
            end

            S_WB_WAIT: begin
                if (mem_resp_valid) state_d = S_FILL_REQ;
            end

            S_FILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = S_FILL_WAIT;
            end

            S_FILL_WAIT: begin
                if (mem_resp_valid) state_d = S_INSTALL;
            end

            S_INSTALL: begin
                meta_we    = 1'b1;
                lru_update = 1'b1;
                state_d    = S_RESP;
            end

            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            we_q       <= 1'b0;
            vic_way_q  <= 4'b0001;
            vic_tag_q  <= '0;
            resp_hit_q <= 1'b0;
            resp_way_q <= 4'b0000;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            we_q       <= we_d;
            vic_way_q  <= vic_way_d;
            vic_tag_q  <= vic_tag_d;
            resp_hit_q <= resp_hit_d;
            resp_way_q <= resp_way_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_hit      = resp_hit_q;
    assign resp_way      = resp_way_q;
    assign lookup_index  = index_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
    assign err_multi_hit = err_q;

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Directed bench for cache_access_sequencer: hits, clean/dirty misses, multi-hit,
// mid-operation reset, counter saturation and response back-pressure.
module tb_cache_access_sequencer;

    localparam int CW   = 4;              // narrow counters so saturation is reachable
    localparam int MAXC = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr;
    logic        req_ready, resp_valid, resp_hit;
    logic [3:0]  resp_way;
    logic [6:0]  lookup_index;
    logic [3:0]  lookup_hit_way, victim_way;
    logic        victim_valid, victim_dirty;
    logic [20:0] victim_tag;
    logic        meta_we, meta_dirty, lru_update;
    logic [3:0]  meta_way, lru_access_way;
    logic [20:0] meta_tag;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [31:0] mem_req_addr;
    logic [CW-1:0] hit_count, miss_count;
    logic        err_multi_hit;

    cache_access_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
        .lookup_index(lookup_index), .lookup_hit_way(lookup_hit_way),
        .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag),
        .meta_we(meta_we), .meta_way(meta_way), .meta_tag(meta_tag), .meta_dirty(meta_dirty),
        .lru_update(lru_update), .lru_access_way(lru_access_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .hit_count(hit_count), .miss_count(miss_count), .err_multi_hit(err_multi_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] way;
    } resp_t;

    resp_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_hits = 0;
    int    exp_misses = 0;
    logic  exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v == MAXC) ? MAXC : v + 1;
    endfunction

    // Drive one request through accept and the LOOKUP cycle; leaves the bench
    // just after the edge that leaves LOOKUP.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] hit,
                         input logic [3:0] vway, input logic vval, input logic vdirty,
                         input logic [20:0] vtag, input logic [3:0] exp_way, input logic exp_multi);
        req_addr = addr; req_we = we; req_valid = 1'b1;
        lookup_hit_way = hit; victim_way = vway; victim_valid = vval;
        victim_dirty = vdirty; victim_tag = vtag;
        #1 check("req_ready before accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_addr  = ~addr;
        #1;
        check("lookup_index", lookup_index, addr[10:4]);
        check("req_ready in lookup", req_ready, 0);
        if (hit != 4'd0) begin
            check("lru_update on hit", lru_update, 1);
            check("lru_access_way on hit", lru_access_way, exp_way);
            check("meta_we on hit", meta_we, we);
            if (we) begin
                check("meta_way write hit", meta_way, exp_way);
                check("meta_tag write hit", meta_tag, addr[31:11]);
                check("meta_dirty write hit", meta_dirty, 1);
            end
            exp_hits = sat_inc(exp_hits);
            if (exp_multi) exp_err = 1'b1;
            sb_q.push_back('{hit: 1'b1, way: exp_way});
        end else begin
            check("lru_update on miss", lru_update, 0);
            check("meta_we on miss", meta_we, 0);
            exp_misses = sat_inc(exp_misses);
            sb_q.push_back('{hit: 1'b0, way: exp_way});
        end
        tick();
        victim_tag = '0;
        victim_way = 4'b0000;
        lookup_hit_way = 4'b0000;
    endtask

    // Memory request phase: ready held low for ready_delay cycles (with a stray
    // response pulse that must be ignored); ends in the matching WAIT state.
    task automatic mem_req(input logic exp_we, input logic [31:0] exp_addr, input int ready_delay);
        for (int i = 0; i < ready_delay; i++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = (i == 0);
            #1;
            check("mem_req_valid held", mem_req_valid, 1);
            check("mem_req_we held", mem_req_we, exp_we);
            check("mem_req_addr held", mem_req_addr, exp_addr);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        check("mem_req_valid", mem_req_valid, 1);
        check("mem_req_we", mem_req_we, exp_we);
        check("mem_req_addr", mem_req_addr, exp_addr);
        tick();
        mem_req_ready = 1'b0;
        #1 check("mem_req_valid while waiting", mem_req_valid, 0);
    endtask

    task automatic mem_resp(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("no mem_req while waiting", mem_req_valid, 0);
        end
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic install(input logic [3:0] way, input logic [20:0] tag, input logic dirty);
        #1;
        check("install meta_we", meta_we, 1);
        check("install meta_way", meta_way, way);
        check("install meta_tag", meta_tag, tag);
        check("install meta_dirty", meta_dirty, dirty);
        check("install lru_update", lru_update, 1);
        check("install lru_access_way", lru_access_way, way);
        check("install no mem_req", mem_req_valid, 0);
        tick();
    endtask

    // In RESP: hold resp_ready low for 'hold' cycles while a competing request is
    // offered, then pop the scoreboard and complete the handshake.
    task automatic wait_resp(input int hold);
        resp_t e;
        e = sb_q.pop_front();
        resp_ready = 1'b0;
        req_valid  = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            #1;
            check("resp_valid held", resp_valid, 1);
            check("resp_way held", resp_way, e.way);
            check("no accept during resp", req_ready, 0);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("resp_valid", resp_valid, 1);
        check("resp_hit", resp_hit, e.hit);
        check("resp_way", resp_way, e.way);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        check("err_multi_hit", err_multi_hit, exp_err);
        check("no meta_we in resp", meta_we, 0);
        tick();
        resp_ready = 1'b0;
        #1;
        check("resp_valid after accept", resp_valid, 0);
        check("req_ready after resp", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; resp_ready = 1'b0;
        lookup_hit_way = '0; victim_way = '0; victim_valid = 1'b0; victim_dirty = 1'b0;
        victim_tag = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset mem_req_valid", mem_req_valid, 0);
        check("reset meta_we", meta_we, 0);
        check("reset lru_update", lru_update, 0);
        check("reset hit_count", hit_count, 0);
        check("reset miss_count", miss_count, 0);
        check("reset err_multi_hit", err_multi_hit, 0);

        // Read hit way 1; response two cycles after accept, then back-pressure 5 cycles.
        issue(32'h0000_1230, 1'b0, 4'b0010, 4'b0001, 1'b1, 1'b0, 21'h0, 4'b0010, 1'b0);
        wait_resp(5);

        // Write hit way 3.
        issue(32'h8000_0450, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b1, 21'h0, 4'b1000, 1'b0);
        wait_resp(0);

        // Read miss, clean valid victim way 2: single refill then install.
        a = 32'h1234_5670;
        issue(a, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 21'h0_0F0F, 4'b0100, 1'b0);
        mem_req(1'b0, {a[31:4], 4'h0}, 1);
        mem_resp(2);
        install(4'b0100, a[31:11], 1'b0);
        wait_resp(0);

        // Write miss, dirty victim way 0 tag 0x1ABCD: writeback (ready low 3 cycles) then refill.
        a = 32'h0000_0A80;
        issue(a, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 21'h1ABCD, 4'b0001, 1'b0);
        mem_req(1'b1, {21'h1ABCD, a[10:4], 4'h0}, 3);
        mem_resp(1);
        mem_req(1'b0, {a[31:4], 4'h0}, 0);
        mem_resp(0);
        install(4'b0001, a[31:11], 1'b1);
        wait_resp(1);

        // Dirty but invalid victim, zero victim vector: no writeback, way 0 chosen.
        a = 32'hFFFF_FFF0;
        issue(a, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 21'h15555, 4'b0001, 1'b0);
        mem_req(1'b0, {a[31:4], 4'h0}, 0);
        mem_resp(0);
        install(4'b0001, a[31:11], 1'b0);
        wait_resp(0);

        // Multi-bit hit vector: lowest bit used, error flag raised.
        issue(32'h0040_0100, 1'b0, 4'b0110, 4'b0001, 1'b1, 1'b0, 21'h0, 4'b0010, 1'b1);
        wait_resp(0);

        // Miss aborted by reset while waiting for the refill.
        a = 32'h0ABC_DEF0;
        issue(a, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 21'h0, 4'b0010, 1'b0);
        mem_req(1'b0, {a[31:4], 4'h0}, 0);
        check("err_multi_hit sticky", err_multi_hit, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort req_ready", req_ready, 1);
        check("abort meta_we", meta_we, 0);
        check("abort lru_update", lru_update, 0);
        check("abort mem_req_valid", mem_req_valid, 0);
        check("abort hit_count", hit_count, 0);
        check("abort miss_count", miss_count, 0);
        check("abort err_multi_hit", err_multi_hit, 0);
        void'(sb_q.pop_front());
        exp_hits = 0; exp_misses = 0; exp_err = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check("stale resp no install", meta_we, 0);
        check("stale resp no lru", lru_update, 0);
        check("stale resp idle", req_ready, 1);

        // Saturate the miss counter, then one more miss must not wrap.
        for (int i = 0; i <= MAXC; i++) begin
            a = 32'h0010_0000 + (i << 4);
            issue(a, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 21'h0, 4'b1000, 1'b0);
            mem_req(1'b0, {a[31:4], 4'h0}, 0);
            mem_resp(0);
            install(4'b1000, a[31:11], 1'b0);
            wait_resp(0);
        end
        check("miss_count saturated", miss_count, MAXC);
        issue(32'h0000_2000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 21'h0, 4'b0001, 1'b0);
        wait_resp(0);
        check("hit_count after saturation", hit_count, 1);
        check("scoreboard drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
